seg_limit_check_pipe: RTL and testbench
=======================================

// Module: seg_limit_check_pipe
// PURPOSE
//  Pipelined, parametrised segment-limit checker for the address-generation stage.
//  Forms offset = base+disp + scaled index and end = offset + size-1.
//  Checks [offset,end] against a per-segment limit register file; normal and expand-down segments.
//  Two-stage valid/ready pipeline with flush; feeds the memory stage with offset and exception flag.
// PARAMETERS
//  NUM_SEGS   6   number of segment limit entries (ES,CS,SS,DS,FS,GS)
//  SEG_ID_W   3   width of segment id; ids >= NUM_SEGS are invalid
//  ADDR_W     32  offset / limit width
//  EXC_CNT_W  8   width of saturating exception counter
// PORTS
//  CLK            in   1         clock
//  RST            in   1         asynchronous, active-high reset
//  FLUSH          in   1         synchronous pipeline flush
//  IN_V           in   1         request valid
//  IN_RDY         out  1         request accepted when IN_V&&IN_RDY
//  MEM_RD         in   1         request reads memory
//  MEM_WR         in   1         request writes memory
//  SEG_ID         in   SEG_ID_W  segment selector index
//  DATA_SIZE      in   2         0=1B 1=2B 2=4B 3=8B
//  ADD_BASE_DISP  in   ADDR_W    base+displacement
//  MUX_SIB_SI     in   ADDR_W    scaled index
//  LIM_WE         in   1         limit register write enable
//  LIM_WR_ID      in   SEG_ID_W  entry written
//  LIM_WR_VAL     in   ADDR_W    new limit
//  LIM_WR_ED      in   1         new expand-down attribute
//  OUT_V          out  1         result valid
//  OUT_RDY        in   1         consumer ready
//  OUT_OFFSET     out  ADDR_W    effective offset (mod 2^ADDR_W)
//  OUT_SEG_ID     out  SEG_ID_W  segment id passed through
//  OUT_EXC        out  1         limit violation (#GP/#SS raised downstream)
//  EXC_CNT        out  EXC_CNT_W saturating count of delivered exceptions
// BEHAVIOUR
//  - Reset: all valids 0, OUT_*=0, EXC_CNT=0, limits = all-ones, expand-down = 0.
//  - S1 (accept): offset = ADD_BASE_DISP+MUX_SIB_SI (wraps, no fault);
//    {ec,end} = offset + (1<<DATA_SIZE)-1, ADDR_W+1 bits.
//  - S2 (check), normal segment: EXC = (end > LIMIT) | ec.
//  - S2, expand-down segment: EXC = (offset <= LIMIT) | ec.
//  - EXC forced 1 if SEG_ID >= NUM_SEGS; EXC forced 0 if !MEM_RD && !MEM_WR (LEA-type pass-through).
//  - Latency: exactly 2 cycles accept->OUT_V when unstalled; throughput 1/cycle.
//  - Handshake: stage advances when downstream empty or advancing; IN_RDY = !s1_v | s1_adv.
//    OUT_* held stable while OUT_V && !OUT_RDY.
//  - Limit write is visible to S2 compares in the cycle after LIM_WE (no bypass).
//    The compare happens in S2, so a held stalled result is NOT re-evaluated.
//    LIM_WR_ID >= NUM_SEGS ignored.
//  - FLUSH: clears s1_v and OUT_V next edge; takes priority over same-cycle accept; EXC_CNT unchanged.
//  - EXC_CNT += 1 on OUT_V && OUT_RDY && OUT_EXC; saturates at all-ones.
//  - RST mid-operation: in-flight requests dropped, limits reloaded to reset values.
// STRUCTURE
//  - Package seg_chk_pkg: seg_id_e (SEG_ES..SEG_GS), size_e, SIZE_BYTES function, seg_attr_t struct {limit, ed}.
//  - Sub-module seg_limit_regfile: NUM_SEGS x seg_attr_t, async-reset, one write port, one comb read port.
//  - Top holds S1/S2 pipeline registers, compare logic and counter.
// TESTING
//  1. Normal DS lim=0x0FFF, off=0x0FFC, size=4B -> OUT_EXC=0 at cycle+2; off=0x0FFD -> OUT_EXC=1.
//  2. Expand-down SS lim=0x1000: off=0x1000 -> EXC=1; off=0x1001, 8B -> EXC=0;
//     off=0xFFFFFFFC, 8B -> EXC=1 (carry).
//  3. Back-to-back 4 requests, OUT_RDY low 3 cycles mid-stream
//     -> IN_RDY drops, no loss/duplication, order preserved, OUT_* stable.
//  4. LIM_WE DS=0x10 same cycle as S2 check of off=0x20 -> EXC=0 (old limit); next request -> EXC=1.
//  5. SEG_ID=7 with MEM_RD=1 -> EXC=1; same with MEM_RD=MEM_WR=0 -> EXC=0.
//  6. FLUSH with both stages full -> OUT_V=0 next cycle; 300 exceptions -> EXC_CNT=255;
//     RST pulse -> EXC_CNT=0, limits=0xFFFFFFFF.

Source files
------------

// File: rtl/seg_chk_pkg.sv
// Shared types for the segment-limit checker: segment ids, access sizes and
// the per-segment attribute record held in the limit register file.
package seg_chk_pkg;

    localparam int unsigned SEG_ADDR_W = 32;

    typedef enum logic [2:0] {
        SegEs = 3'd0,
        SegCs = 3'd1,
        SegSs = 3'd2,
        SegDs = 3'd3,
        SegFs = 3'd4,
        SegGs = 3'd5
    } seg_id_e;

    typedef enum logic [1:0] {
        Size1B = 2'd0,
        Size2B = 2'd1,
        Size4B = 2'd2,
        Size8B = 2'd3
    } size_e;

    typedef struct packed {
        logic [SEG_ADDR_W-1:0] limit;
        logic                  ed;
    } seg_attr_t;

    localparam seg_attr_t SEG_ATTR_RST = '{limit: '1, ed: 1'b0};

    function automatic logic [3:0] size_bytes(input size_e sz);
        unique case (sz)
            Size1B:  return 4'd1;
            Size2B:  return 4'd2;
            Size4B:  return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/seg_limit_regfile.sv
// Per-segment limit/expand-down attributes: one write port, one combinational
// read port. Out-of-range ids are ignored on write and read back as reset value.
module seg_limit_regfile
    import seg_chk_pkg::*;
#(
    parameter int unsigned NUM_SEGS = 6,
    parameter int unsigned SEG_ID_W = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [SEG_ID_W-1:0] wr_id_i,
    input  seg_attr_t           wr_attr_i,
    input  logic [SEG_ID_W-1:0] rd_id_i,
    output seg_attr_t           rd_attr_o
);

    localparam logic [SEG_ID_W:0] NumSegsW = NUM_SEGS[SEG_ID_W:0];

    seg_attr_t attr_q [NUM_SEGS];

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = {1'b0, wr_id_i} < NumSegsW;
    assign rd_ok = {1'b0, rd_id_i} < NumSegsW;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SEGS; i++) begin
                attr_q[i] <= SEG_ATTR_RST;
            end
        end else if (we_i && wr_ok) begin
            attr_q[wr_id_i] <= wr_attr_i;
        end
    end

    always_comb begin
        rd_attr_o = SEG_ATTR_RST;
        if (rd_ok) begin
            rd_attr_o = attr_q[rd_id_i];
        end
    end

endmodule

// File: rtl/seg_limit_check_pipe.sv
// Two-stage segment-limit checker: S1 forms offset/end, S2 compares against the
// limit file and registers the result for the memory stage.
module seg_limit_check_pipe
    import seg_chk_pkg::*;
#(
    parameter int unsigned NUM_SEGS  = 6,
    parameter int unsigned SEG_ID_W  = 3,
    parameter int unsigned ADDR_W    = SEG_ADDR_W,
    parameter int unsigned EXC_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_v_i,
    output logic                 in_rdy_o,
    input  logic                 mem_rd_i,
    input  logic                 mem_wr_i,
    input  logic [SEG_ID_W-1:0]  seg_id_i,
    input  logic [1:0]           data_size_i,
    input  logic [ADDR_W-1:0]    add_base_disp_i,
    input  logic [ADDR_W-1:0]    mux_sib_si_i,
    input  logic                 lim_we_i,
    input  logic [SEG_ID_W-1:0]  lim_wr_id_i,
    input  logic [ADDR_W-1:0]    lim_wr_val_i,
    input  logic                 lim_wr_ed_i,
    output logic                 out_v_o,
    input  logic                 out_rdy_i,
    output logic [ADDR_W-1:0]    out_offset_o,
    output logic [SEG_ID_W-1:0]  out_seg_id_o,
    output logic                 out_exc_o,
    output logic [EXC_CNT_W-1:0] exc_cnt_o
);

    localparam logic [SEG_ID_W:0] NumSegsW = NUM_SEGS[SEG_ID_W:0];

    // S1 state
    logic                s1_v_q, s1_v_d;
    logic [ADDR_W-1:0]   s1_offset_q;
    logic [ADDR_W-1:0]   s1_end_q;
    logic                s1_ec_q;
    logic [SEG_ID_W-1:0] s1_seg_q;
    logic                s1_mem_q;

    // S2 / output state
    logic                 out_v_q, out_v_d;
    logic [ADDR_W-1:0]    out_offset_q;
    logic [SEG_ID_W-1:0]  out_seg_q;
    logic                 out_exc_q;
    logic [EXC_CNT_W-1:0] exc_cnt_q, exc_cnt_d;

    logic              out_adv;
    logic              s1_adv;
    logic              accept;
    logic [ADDR_W-1:0] offset_d;
    logic [3:0]        size_m1;
    logic [ADDR_W:0]   end_full;
    logic              seg_ok;
    logic              s2_exc;
    seg_attr_t         wr_attr;
    seg_attr_t         rd_attr;

    assign out_adv  = !out_v_q || out_rdy_i;
    assign s1_adv   = s1_v_q && out_adv;
    assign in_rdy_o = !s1_v_q || s1_adv;
    assign accept   = in_v_i && in_rdy_o && !flush_i;

    // Address wrap on the offset is legal; only the access end carry faults.
    assign offset_d = add_base_disp_i + mux_sib_si_i;
    assign size_m1  = size_bytes(size_e'(data_size_i)) - 4'd1;
    assign end_full = {1'b0, offset_d} + {{(ADDR_W-3){1'b0}}, size_m1};

    always_comb begin
        s1_v_d = s1_v_q;
        if (flush_i) begin
            s1_v_d = 1'b0;
        end else if (in_rdy_o) begin
            s1_v_d = in_v_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_v_q      <= 1'b0;
            s1_offset_q <= '0;
            s1_end_q    <= '0;
            s1_ec_q     <= 1'b0;
            s1_seg_q    <= '0;
            s1_mem_q    <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            if (accept) begin
                s1_offset_q <= offset_d;
                s1_end_q    <= end_full[ADDR_W-1:0];
                s1_ec_q     <= end_full[ADDR_W];
                s1_seg_q    <= seg_id_i;
                s1_mem_q    <= mem_rd_i || mem_wr_i;
            end
        end
    end

    assign wr_attr = '{limit: lim_wr_val_i, ed: lim_wr_ed_i};

    seg_limit_regfile #(
        .NUM_SEGS (NUM_SEGS),
        .SEG_ID_W (SEG_ID_W)
    ) u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (lim_we_i),
        .wr_id_i   (lim_wr_id_i),
        .wr_attr_i (wr_attr),
        .rd_id_i   (s1_seg_q),
        .rd_attr_o (rd_attr)
    );

    assign seg_ok = {1'b0, s1_seg_q} < NumSegsW;

    always_comb begin
        s2_exc = 1'b0;
        if (!s1_mem_q) begin
            s2_exc = 1'b0;
        end else if (!seg_ok) begin
            s2_exc = 1'b1;
        end else if (rd_attr.ed) begin
            s2_exc = (s1_offset_q <= rd_attr.limit) || s1_ec_q;
        end else begin
            s2_exc = (s1_end_q > rd_attr.limit) || s1_ec_q;
        end
    end

    always_comb begin
        out_v_d = out_v_q;
        if (flush_i) begin
            out_v_d = 1'b0;
        end else if (out_adv) begin
            out_v_d = s1_v_q;
        end
    end

    always_comb begin
        exc_cnt_d = exc_cnt_q;
        if (out_v_q && out_rdy_i && out_exc_q && (exc_cnt_q != '1)) begin
            exc_cnt_d = exc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_v_q      <= 1'b0;
            out_offset_q <= '0;
            out_seg_q    <= '0;
            out_exc_q    <= 1'b0;
            exc_cnt_q    <= '0;
        end else begin
            out_v_q   <= out_v_d;
            exc_cnt_q <= exc_cnt_d;
            // Result is captured once; a stalled result keeps its verdict.
            if (s1_adv) begin
                out_offset_q <= s1_offset_q;
                out_seg_q    <= s1_seg_q;
                out_exc_q    <= s2_exc;
            end
        end
    end

    assign out_v_o      = out_v_q;
    assign out_offset_o = out_offset_q;
    assign out_seg_id_o = out_seg_q;
    assign out_exc_o    = out_exc_q;
    assign exc_cnt_o    = exc_cnt_q;

endmodule

// File: tb/tb_seg_limit_check_pipe.sv
// Directed and random checks of seg_limit_check_pipe against a queue-based
// reference model of the limit rules.
module tb_seg_limit_check_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_v, in_rdy, mem_rd, mem_wr;
    logic [2:0]  seg_id, lim_id, out_seg;
    logic [1:0]  data_size;
    logic [31:0] base, idx, lim_val, out_offset;
    logic        lim_we, lim_ed, out_v, out_rdy, out_exc;
    logic [7:0]  exc_cnt;

    always #5 clk = ~clk;

    seg_limit_check_pipe dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .in_v_i          (in_v),
        .in_rdy_o        (in_rdy),
        .mem_rd_i        (mem_rd),
        .mem_wr_i        (mem_wr),
        .seg_id_i        (seg_id),
        .data_size_i     (data_size),
        .add_base_disp_i (base),
        .mux_sib_si_i    (idx),
        .lim_we_i        (lim_we),
        .lim_wr_id_i     (lim_id),
        .lim_wr_val_i    (lim_val),
        .lim_wr_ed_i     (lim_ed),
        .out_v_o         (out_v),
        .out_rdy_i       (out_rdy),
        .out_offset_o    (out_offset),
        .out_seg_id_o    (out_seg),
        .out_exc_o       (out_exc),
        .exc_cnt_o       (exc_cnt)
    );

    typedef struct {
        logic [31:0] off;
        logic [2:0]  sid;
        logic        exc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mlim [6];
    logic        med  [6];
    int unsigned mcnt;
    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    logic        acc_flag, rdy_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: the access [off, off+size-1] must not cross 2^32 and must
    // lie inside the segment (above the limit for expand-down segments).
    function automatic logic model_exc(input logic rd, input logic wr, input logic [2:0] sid,
                                       input logic [1:0] sz, input logic [31:0] off);
        longint unsigned first, last;
        if (!rd && !wr) return 1'b0;
        if (sid >= 3'd6) return 1'b1;
        first = {32'd0, off};
        last  = first + (64'd1 << sz) - 64'd1;
        if (last > 64'hFFFF_FFFF) return 1'b1;
        if (med[sid]) return first <= {32'd0, mlim[sid]};
        return last > {32'd0, mlim[sid]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            mlim[i] = 32'hFFFF_FFFF;
            med[i]  = 1'b0;
        end
        exp_q.delete();
        mcnt = 0;
    endtask

    // One clock: settle inputs, update the model, step, then check held outputs.
    task automatic cycle();
        logic        held, pop;
        logic [31:0] h_off;
        logic [2:0]  h_sid;
        logic        h_exc;
        exp_t        e;
        held = 1'b0;
        pop = 1'b0;
        acc_flag = 1'b0;
        #1;
        rdy_seen = in_rdy;
        if (!rst) begin
            if (lim_we && lim_id < 3'd6) begin
                mlim[lim_id] = lim_val;
                med[lim_id]  = lim_ed;
            end
            if (out_v && out_rdy && !flush) begin
                pop = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_offset", out_offset, e.off);
                    chk("out_seg", out_seg, e.sid);
                    chk("out_exc", out_exc, e.exc);
                    if (e.exc && mcnt < 255) mcnt++;
                    pops++;
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_v && in_rdy) begin
                acc_flag = 1'b1;
                e.off = base + idx;
                e.sid = seg_id;
                e.exc = model_exc(mem_rd, mem_wr, seg_id, data_size, base + idx);
                exp_q.push_back(e);
            end
            if (out_v && !out_rdy && !flush) begin
                held  = 1'b1;
                h_off = out_offset;
                h_sid = out_seg;
                h_exc = out_exc;
            end
        end
        @(posedge clk);
        #1;
        if (held) begin
            chk("hold_v", out_v, 1);
            chk("hold_off", out_offset, h_off);
            chk("hold_seg", out_seg, h_sid);
            chk("hold_exc", out_exc, h_exc);
        end
        if (pop) chk("exc_cnt", exc_cnt, mcnt);
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic [2:0] sid,
                           input logic [1:0] sz, input logic [31:0] b, input logic [31:0] x);
        mem_rd = rd; mem_wr = wr; seg_id = sid; data_size = sz; base = b; idx = x;
    endtask

    task automatic write_lim(input logic [2:0] id, input logic [31:0] val, input logic ed);
        lim_we = 1'b1; lim_id = id; lim_val = val; lim_ed = ed;
        cycle();
        lim_we = 1'b0;
    endtask

    // Single request into an idle pipe: result must appear exactly 2 cycles later.
    task automatic send_one(input string tag, input logic rd, input logic wr, input logic [2:0] sid,
                            input logic [1:0] sz, input logic [31:0] b, input logic [31:0] x,
                            input logic exp_exc);
        out_rdy = 1'b1;
        set_req(rd, wr, sid, sz, b, x);
        in_v = 1'b1;
        cycle();
        in_v = 1'b0;
        chk({tag, "_lat1"}, out_v, 0);
        cycle();
        chk({tag, "_lat2"}, out_v, 1);
        chk({tag, "_exc"}, out_exc, exp_exc);
    endtask

    task automatic drain();
        in_v = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || out_v); i++) cycle();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int sent, pops0;
        logic saw_low;
        logic [31:0] rlim [6];
        rst = 1'b1; flush = 1'b0; in_v = 1'b0; out_rdy = 1'b1; lim_we = 1'b0;
        lim_id = '0; lim_val = '0; lim_ed = 1'b0;
        set_req(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0);
        model_reset();
        #1;
        chk("rst_out_v", out_v, 0);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_offset", out_offset, 0);
        chk("rst_exc", out_exc, 0);
        chk("rst_cnt", exc_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle();

        // Normal DS segment
        write_lim(3'd3, 32'h0000_0FFF, 1'b0);
        send_one("ds_fit", 1'b1, 1'b0, 3'd3, 2'd2, 32'h0000_0FF0, 32'h0000_000C, 1'b0);
        send_one("ds_over", 1'b1, 1'b0, 3'd3, 2'd2, 32'h0000_0FF0, 32'h0000_000D, 1'b1);

        // Expand-down SS segment
        write_lim(3'd2, 32'h0000_1000, 1'b1);
        send_one("ss_at_lim", 1'b1, 1'b0, 3'd2, 2'd0, 32'h0000_1000, 32'h0, 1'b1);
        send_one("ss_above", 1'b0, 1'b1, 3'd2, 2'd3, 32'h0000_1000, 32'h1, 1'b0);
        send_one("ss_carry", 1'b1, 1'b0, 3'd2, 2'd3, 32'hFFFF_FFF0, 32'hC, 1'b1);

        // Limit write while the request sits in S1 uses the old limit
        out_rdy = 1'b1;
        set_req(1'b1, 1'b0, 3'd3, 2'd0, 32'h20, 32'h0);
        in_v = 1'b1;
        cycle();
        in_v = 1'b0;
        lim_we = 1'b1; lim_id = 3'd3; lim_val = 32'h10; lim_ed = 1'b0;
        cycle();
        lim_we = 1'b0;
        chk("limwr_v", out_v, 1);
        chk("limwr_old", out_exc, 0);
        send_one("limwr_new", 1'b1, 1'b0, 3'd3, 2'd0, 32'h20, 32'h0, 1'b1);

        // Invalid segment id and LEA pass-through
        send_one("bad_seg_rd", 1'b1, 1'b0, 3'd7, 2'd0, 32'h40, 32'h0, 1'b1);
        send_one("bad_seg_lea", 1'b0, 1'b0, 3'd7, 2'd0, 32'h40, 32'h0, 1'b0);
        drain();

        // Back-to-back with a 3-cycle consumer stall
        sent = 0; saw_low = 1'b0; pops0 = pops;
        for (int c = 0; c < 30 && (sent < 4 || exp_q.size() != 0); c++) begin
            out_rdy = !(c >= 3 && c < 6);
            in_v = (sent < 4);
            set_req(1'b1, sent[0], 3'd3, sent[1:0], 32'h8 + 32'(sent * 4), 32'h0);
            cycle();
            if (!rdy_seen) saw_low = 1'b1;
            if (acc_flag) sent++;
        end
        in_v = 1'b0;
        chk("b2b_sent", sent, 4);
        chk("b2b_pops", pops - pops0, 4);
        chk("b2b_rdy_drop", saw_low, 1);
        drain();

        // Random traffic against random limits
        for (int s = 0; s < 6; s++) begin
            rlim[s] = $urandom_range(32'h0000_F000, 32'h0000_0100);
            write_lim(3'(s), rlim[s], 1'($urandom_range(1, 0)));
        end
        for (int c = 0; c < 400; c++) begin
            logic [2:0] sid;
            sid = 3'($urandom_range(7, 0));
            in_v = ($urandom_range(3, 0) != 0);
            out_rdy = ($urandom_range(3, 0) != 0);
            if (sid < 3'd6 && $urandom_range(3, 0) != 0)
                base = rlim[sid] + 32'($urandom_range(16, 0)) - 32'd8;
            else if ($urandom_range(1, 0) != 0)
                base = 32'hFFFF_FFF8 + 32'($urandom_range(7, 0));
            else
                base = $urandom;
            idx = ($urandom_range(1, 0) != 0) ? 32'($urandom_range(3, 0)) : 32'h0;
            seg_id = sid;
            data_size = 2'($urandom_range(3, 0));
            mem_rd = ($urandom_range(3, 0) != 0);
            mem_wr = 1'($urandom_range(1, 0));
            cycle();
        end
        drain();

        // Flush with both stages full
        out_rdy = 1'b0;
        set_req(1'b1, 1'b0, 3'd7, 2'd0, 32'h100, 32'h0);
        in_v = 1'b1;
        cycle();
        cycle();
        in_v = 1'b0;
        #1;
        chk("full_out_v", out_v, 1);
        chk("full_in_rdy", in_rdy, 0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_out_v", out_v, 0);
        chk("flush_cnt", exc_cnt, mcnt);
        out_rdy = 1'b1;
        cycle();
        cycle();
        chk("flush_s1_gone", out_v, 0);

        // Saturating exception counter
        out_rdy = 1'b1;
        set_req(1'b1, 1'b0, 3'd7, 2'd0, 32'h200, 32'h0);
        in_v = 1'b1;
        for (int c = 0; c < 300; c++) cycle();
        drain();
        chk("cnt_sat", exc_cnt, 255);

        // Reset mid-operation reloads limits and drops in-flight work
        write_lim(3'd3, 32'h10, 1'b0);
        write_lim(3'd2, 32'h1000, 1'b1);
        set_req(1'b1, 1'b0, 3'd3, 2'd0, 32'h300, 32'h0);
        in_v = 1'b1;
        cycle();
        in_v = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst2_out_v", out_v, 0);
        chk("rst2_cnt", exc_cnt, 0);
        model_reset();
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst2_dropped", out_v, 0);
        send_one("rst2_ds_lim", 1'b1, 1'b0, 3'd3, 2'd0, 32'hFFFF_FFF0, 32'h0, 1'b0);
        send_one("rst2_ss_ed", 1'b1, 1'b0, 3'd2, 2'd0, 32'h10, 32'h0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
